// File: rtl/packet_word_packer_pkg.sv
// packet_word_packer_pkg: shared types and constants
// for the receive-side byte-to-word packer.
package packet_word_packer_pkg;

  typedef enum logic {
    IDLE,
    FILL
  } packer_state_t;

  localparam int FRAME_CNT_WIDTH = 16;

  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/packet_word_packer_oreg.sv
// packet_word_packer_oreg: output holding register
// with AXI-Stream style valid/ready.
// Ports: clk_i, arstn_i; load_i/data_i/keep_i/last_i
// from the producer; in_ready_o back to it;
// m_tdata_o/m_tkeep_o/m_tlast_o/m_tvalid_o/m_tready_i
// toward the consumer.
module packet_word_packer_oreg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic [KEEP_W-1:0] m_tkeep_o,
  output logic              m_tvalid_o,
  output logic              m_tlast_o,
  input  logic              m_tready_i
);

  logic take;

  // A new word may enter when empty or when the
  // current one drains in the same cycle.
  assign in_ready_o = !m_tvalid_o | m_tready_i;
  assign take       = load_i & in_ready_o;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tkeep_o  <= '0;
      m_tlast_o  <= 1'b0;
    end else if (take) begin
      m_tvalid_o <= 1'b1;
      m_tdata_o  <= data_i;
      m_tkeep_o  <= keep_i;
      m_tlast_o  <= last_i;
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_word_packer.sv
// packet_word_packer: packs a byte stream little-endian
// into OUT_WIDTH-bit words with keep and tlast.
// Ports: clk_i, arstn_i (async active-low);
// s_t* byte slave; m_t* word master;
// frame_done_o/frame_len_o/frame_cnt_o frame stats;
// expected_len_i/len_err_o length check, active only
// when PACKET_WORD_PACKER_LEN_CHECK_EN is defined.
module packet_word_packer
  import packet_word_packer_pkg::*;
#(
  parameter int OUT_WIDTH     = 32,
  parameter int PAYLOAD_WIDTH = 11
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic [7:0]                 s_tdata_i,
  input  logic                       s_tvalid_i,
  input  logic                       s_tlast_i,
  output logic                       s_tready_o,
  output logic [OUT_WIDTH-1:0]       m_tdata_o,
  output logic [OUT_WIDTH/8-1:0]     m_tkeep_o,
  output logic                       m_tvalid_o,
  output logic                       m_tlast_o,
  input  logic                       m_tready_i,
  output logic                       frame_done_o,
  output logic [PAYLOAD_WIDTH-1:0]   frame_len_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  input  logic [PAYLOAD_WIDTH-1:0]   expected_len_i,
  output logic                       len_err_o
);

  localparam int LANES  = OUT_WIDTH / 8;
  localparam int LANE_W = lane_bits(LANES);

  localparam logic [LANE_W-1:0] LAST_LANE =
    LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0] LANE_ONE =
    LANE_W'(1);
  localparam logic [PAYLOAD_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [PAYLOAD_WIDTH-1:0] LEN_ONE =
    PAYLOAD_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE =
    FRAME_CNT_WIDTH'(1);

  packer_state_t            state;
  logic [LANE_W-1:0]        lane;
  logic [OUT_WIDTH-1:0]     acc;
  logic [OUT_WIDTH-1:0]     word;
  logic [LANES-1:0]         keep;
  logic [PAYLOAD_WIDTH-1:0] byte_cnt;
  logic [PAYLOAD_WIDTH-1:0] cnt_next;
  logic                     accept;
  logic                     at_top;
  logic                     close;
  logic                     wrap;
  logic                     fill;
  logic                     emit;

  assign accept = s_tvalid_i & s_tready_o;
  assign at_top = (lane == LAST_LANE);

  // Mutually exclusive actions for an accepted byte.
  assign close = accept & s_tlast_i;
  assign wrap  = accept & !s_tlast_i & at_top;
  assign fill  = accept & !s_tlast_i & !at_top;
  assign emit  = close | wrap;

  // First byte of a frame restarts the count at one;
  // later bytes count up and stick at the maximum.
  always_comb begin
    cnt_next = LEN_ONE;
    if (state == FILL) begin
      cnt_next = (byte_cnt == LEN_MAX) ? byte_cnt
                                       : byte_cnt + LEN_ONE;
    end
  end

  // Unfilled lanes of acc are always zero, so the merge
  // only overwrites the current lane.
  always_comb begin
    word = acc;
    keep = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane == LANE_W'(k)) begin
        word[8*k +: 8] = s_tdata_i;
      end
      keep[k] = (LANE_W'(k) <= lane);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state        <= IDLE;
      lane         <= '0;
      acc          <= '0;
      byte_cnt     <= '0;
      frame_done_o <= 1'b0;
      frame_len_o  <= '0;
      frame_cnt_o  <= '0;
    end else begin
      frame_done_o <= 1'b0;
      unique case (1'b1)
        close: begin
          state        <= IDLE;
          lane         <= '0;
          acc          <= '0;
          byte_cnt     <= '0;
          frame_done_o <= 1'b1;
          frame_len_o  <= cnt_next;
          frame_cnt_o  <= frame_cnt_o + CNT_ONE;
        end
        wrap: begin
          state    <= FILL;
          lane     <= '0;
          acc      <= '0;
          byte_cnt <= cnt_next;
        end
        fill: begin
          state    <= FILL;
          lane     <= lane + LANE_ONE;
          acc      <= word;
          byte_cnt <= cnt_next;
        end
        default: ;
      endcase
    end
  end

  packet_word_packer_oreg #(
    .DATA_W (OUT_WIDTH),
    .KEEP_W (LANES)
  ) u_oreg (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .load_i     (emit),
    .data_i     (word),
    .keep_i     (keep),
    .last_i     (s_tlast_i),
    .in_ready_o (s_tready_o),
    .m_tdata_o  (m_tdata_o),
    .m_tkeep_o  (m_tkeep_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tlast_o  (m_tlast_o),
    .m_tready_i (m_tready_i)
  );

`ifdef PACKET_WORD_PACKER_LEN_CHECK_EN
  logic [PAYLOAD_WIDTH-1:0] exp_len_q;
  logic [PAYLOAD_WIDTH-1:0] exp_len;

  // A single-byte frame closes on the same cycle it
  // would be sampled, so compare the live input then.
  assign exp_len = (state == IDLE) ? expected_len_i
                                   : exp_len_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      exp_len_q <= '0;
      len_err_o <= 1'b0;
    end else begin
      len_err_o <= close & (cnt_next != exp_len);
      if (accept && state == IDLE) begin
        exp_len_q <= expected_len_i;
      end
    end
  end
`else
  logic unused_expected_len;

  assign unused_expected_len = ^expected_len_i;
  assign len_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_packet_word_packer.sv
// tb_packet_word_packer: directed table, corner sequences
// and randomized frames against a frame-level model.
module tb_packet_word_packer;
  import packet_word_packer_pkg::*;

  localparam int OW = 32;
  localparam int PW = 11;
  localparam int LN = OW / 8;
  localparam int LEN_MAX = (1 << PW) - 1;
  localparam int NV = 7;

  logic           clk_i = 1'b0;
  logic           arstn_i;
  logic [7:0]     s_tdata_i;
  logic           s_tvalid_i;
  logic           s_tlast_i;
  logic           s_tready_o;
  logic [OW-1:0]  m_tdata_o;
  logic [LN-1:0]  m_tkeep_o;
  logic           m_tvalid_o;
  logic           m_tlast_o;
  logic           m_tready_i;
  logic           frame_done_o;
  logic [PW-1:0]  frame_len_o;
  logic [15:0]    frame_cnt_o;
  logic [PW-1:0]  expected_len_i;
  logic           len_err_o;

  packet_word_packer #(
    .OUT_WIDTH     (OW),
    .PAYLOAD_WIDTH (PW)
  ) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .s_tdata_i      (s_tdata_i),
    .s_tvalid_i     (s_tvalid_i),
    .s_tlast_i      (s_tlast_i),
    .s_tready_o     (s_tready_o),
    .m_tdata_o      (m_tdata_o),
    .m_tkeep_o      (m_tkeep_o),
    .m_tvalid_o     (m_tvalid_o),
    .m_tlast_o      (m_tlast_o),
    .m_tready_i     (m_tready_i),
    .frame_done_o   (frame_done_o),
    .frame_len_o    (frame_len_o),
    .frame_cnt_o    (frame_cnt_o),
    .expected_len_i (expected_len_i),
    .len_err_o      (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [OW-1:0] data;
    logic [LN-1:0] keep;
    logic          last;
  } word_t;

  typedef struct {
    int   len;
    logic err;
  } done_t;

  typedef struct {
    int            n;
    logic [7:0]    base;
    logic [31:0]   w0;
    logic [3:0]    k0;
    logic [31:0]   wl;
    logic [3:0]    kl;
    int            nw;
    logic [PW-1:0] el;
    logic          err;
  } vec_t;

  word_t         exp_w[$];
  done_t         exp_d[$];
  logic [7:0]    fb[$];
  int            checks = 0;
  int            errors = 0;
  int            n_done = 0;
  int            n_frames = 0;
  int            ready_mode = 2;
  logic [PW-1:0] last_len = '0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, got, exp);
    end
  endtask

  function automatic logic err_sel(input logic e);
`ifdef PACKET_WORD_PACKER_LEN_CHECK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  // Frame-level model: split bytes into LN-byte groups.
  task automatic model_frame(input bit closed,
                             input logic [PW-1:0] el);
    int    n;
    int    nw;
    int    sl;
    word_t w;
    n  = fb.size();
    nw = closed ? (n + LN - 1) / LN : n / LN;
    for (int wi = 0; wi < nw; wi++) begin
      w.data = '0;
      w.keep = '0;
      w.last = closed && (wi == nw - 1);
      for (int j = 0; j < LN; j++) begin
        if (wi * LN + j < n) begin
          w.data[8*j +: 8] = fb[wi * LN + j];
          w.keep[j] = 1'b1;
        end
      end
      exp_w.push_back(w);
    end
    if (closed) begin
      sl = (n > LEN_MAX) ? LEN_MAX : n;
      exp_d.push_back('{sl, err_sel(sl != int'(el))});
    end
  endtask

  initial begin
    m_tready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      case (ready_mode)
        0:       m_tready_i = 1'b1;
        1:       m_tready_i = ($urandom_range(0, 3) != 0);
        default: m_tready_i = 1'b0;
      endcase
    end
  end

  task automatic idle();
    @(negedge clk_i);
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic last,
                           input logic [PW-1:0] el);
    int t;
    t = 0;
    @(negedge clk_i);
    s_tdata_i      = b;
    s_tlast_i      = last;
    s_tvalid_i     = 1'b1;
    expected_len_i = el;
    #1;
    while (!s_tready_o && t < 200) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    if (!s_tready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_tready_o 0 for %0d cycles, expected 1", t);
    end
    @(posedge clk_i);
  endtask

  task automatic send_bytes(input bit closed,
                            input logic [PW-1:0] el,
                            input bit gaps,
                            input bit chain);
    int n;
    n = fb.size();
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i], closed && (i == n - 1),
                (i == 0) ? el : PW'($urandom));
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) idle();
      end
    end
    if (!chain) idle();
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_w.size() != 0 || exp_d.size() != 0)
           && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    repeat (4) @(negedge clk_i);
    checks++;
    if (exp_w.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words %0d frames pending, expected 0",
               name, exp_w.size(), exp_d.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    arstn_i    = 1'b0;
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    n_frames   = 0;
    last_len   = '0;
    exp_w.delete();
    exp_d.delete();
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
  endtask

  // Output monitor: words, hold-while-stalled, stats.
  initial begin
    word_t e;
    word_t held;
    done_t d;
    bit    pend;
    pend = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!arstn_i) begin
        pend = 1'b0;
      end else begin
        chk("s_tready_rule", s_tready_o,
            !m_tvalid_o || m_tready_i);
        if (pend) begin
          chk("hold_valid", m_tvalid_o, 1);
          chk("hold_data", m_tdata_o, held.data);
          chk("hold_keep", m_tkeep_o, held.keep);
          chk("hold_last", m_tlast_o, held.last);
        end
        pend      = m_tvalid_o && !m_tready_i;
        held.data = m_tdata_o;
        held.keep = m_tkeep_o;
        held.last = m_tlast_o;
        if (m_tvalid_o && m_tready_i) begin
          if (exp_w.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got 0x%0h, expected none",
                     m_tdata_o);
          end else begin
            e = exp_w.pop_front();
            chk("word_data", m_tdata_o, e.data);
            chk("word_keep", m_tkeep_o, e.keep);
            chk("word_last", m_tlast_o, e.last);
          end
        end
        if (frame_done_o) begin
          n_done++;
          n_frames++;
          chk("done_with_last", m_tvalid_o && m_tlast_o, 1);
          chk("frame_cnt", frame_cnt_o, 16'(n_frames));
          if (exp_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_done: got len %0d, expected none",
                     frame_len_o);
          end else begin
            d = exp_d.pop_front();
            chk("frame_len", frame_len_o, d.len);
            chk("len_err", len_err_o, d.err);
          end
          last_len = frame_len_o;
        end else begin
          chk("frame_len_hold", frame_len_o, last_len);
          chk("len_err_idle", len_err_o, 0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[NV];
    word_t         w;
    int            d0;
    int            n;
    logic [PW-1:0] el;

    tbl[0] = '{8, 8'h01, 32'h04030201, 4'hF,
               32'h08070605, 4'hF, 2, 11'd8, 1'b0};
    tbl[1] = '{5, 8'hA0, 32'hA3A2A1A0, 4'hF,
               32'h000000A4, 4'h1, 2, 11'd5, 1'b0};
    tbl[2] = '{1, 8'h55, 32'h00000055, 4'h1,
               32'h00000055, 4'h1, 1, 11'd1, 1'b0};
    tbl[3] = '{3, 8'hC0, 32'h00C2C1C0, 4'h7,
               32'h00C2C1C0, 4'h7, 1, 11'd3, 1'b0};
    tbl[4] = '{6, 8'hE0, 32'hE3E2E1E0, 4'hF,
               32'h0000E5E4, 4'h3, 2, 11'd6, 1'b0};
    tbl[5] = '{7, 8'h70, 32'h73727170, 4'hF,
               32'h00767574, 4'h7, 2, 11'd6, 1'b1};
    tbl[6] = '{2, 8'h0F, 32'h0000100F, 4'h3,
               32'h0000100F, 4'h3, 1, 11'd9, 1'b1};

    arstn_i        = 1'b0;
    s_tdata_i      = '0;
    s_tvalid_i     = 1'b0;
    s_tlast_i      = 1'b0;
    expected_len_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_m_tvalid", m_tvalid_o, 0);
    chk("rst_m_tdata", m_tdata_o, 0);
    chk("rst_m_tkeep", m_tkeep_o, 0);
    chk("rst_m_tlast", m_tlast_o, 0);
    chk("rst_s_tready", s_tready_o, 1);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_frame_len", frame_len_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_len_err", len_err_o, 0);
    @(negedge clk_i);
    arstn_i    = 1'b1;
    ready_mode = 0;

    for (int k = 0; k < NV; k++) begin
      if (tbl[k].nw == 2) begin
        w.data = tbl[k].w0;
        w.keep = tbl[k].k0;
        w.last = 1'b0;
        exp_w.push_back(w);
      end
      w.data = tbl[k].wl;
      w.keep = tbl[k].kl;
      w.last = 1'b1;
      exp_w.push_back(w);
      exp_d.push_back('{tbl[k].n, err_sel(tbl[k].err)});
      d0 = n_done;
      fb.delete();
      for (int i = 0; i < tbl[k].n; i++) begin
        fb.push_back(tbl[k].base + 8'(i));
      end
      send_bytes(1, tbl[k].el, 0, 0);
      chk("tbl_state_idle", dut.state, IDLE);
      wait_drain("tbl");
      chk("tbl_len", frame_len_o, tbl[k].n);
      chk("tbl_cnt", frame_cnt_o, k + 1);
      chk("tbl_pulses", n_done - d0, 1);
    end

    fb.delete();
    for (int i = 0; i < 12; i++) fb.push_back(8'hB0 + 8'(i));
    model_frame(1, 11'd12);
    fork
      send_bytes(1, 11'd12, 0, 0);
      begin
        repeat (3) @(negedge clk_i);
        ready_mode = 2;
        repeat (6) @(negedge clk_i);
        #2;
        chk("stall_valid", m_tvalid_o, 1);
        chk("stall_s_tready", s_tready_o, 0);
        repeat (4) @(negedge clk_i);
        ready_mode = 0;
      end
    join
    wait_drain("stall");
    chk("stall_len", frame_len_o, 12);

    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(8'h20 + 8'(i));
    model_frame(0, 11'd0);
    send_bytes(0, 11'd6, 0, 0);
    @(negedge clk_i);
    chk("abort_pre_reset", exp_w.size(), 0);
    do_reset();
    #1;
    chk("abort_state", dut.state, IDLE);
    chk("abort_cnt_clear", frame_cnt_o, 0);
    chk("abort_valid_clear", m_tvalid_o, 0);
    w.data = 32'h13121110;
    w.keep = 4'hF;
    w.last = 1'b1;
    exp_w.push_back(w);
    exp_d.push_back('{4, 1'b0});
    fb.delete();
    for (int i = 0; i < 4; i++) fb.push_back(8'h10 + 8'(i));
    send_bytes(1, 11'd4, 0, 0);
    wait_drain("abort");
    chk("abort_cnt", frame_cnt_o, 1);
    chk("abort_len", frame_len_o, 4);

    fb.delete();
    for (int i = 0; i < LEN_MAX + 3; i++) begin
      fb.push_back(8'(i));
    end
    model_frame(1, PW'(LEN_MAX));
    send_bytes(1, PW'(LEN_MAX), 0, 0);
    wait_drain("long");
    chk("long_sat_len", frame_len_o, LEN_MAX);

    ready_mode = 1;
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(1, 24);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      el = ($urandom_range(0, 1) != 0)
           ? PW'(n) : PW'($urandom_range(1, 24));
      model_frame(1, el);
      send_bytes(1, el, 1, $urandom_range(0, 1) != 0);
    end
    idle();
    wait_drain("random");
    chk("random_cnt", frame_cnt_o, 16'(n_frames));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
